// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller of a dual-clock FIFO. Everything here runs on the
// read clock. The already-synchronized Gray write pointer is decoded to
// binary and compared with the local binary read pointer. While storage holds
// unread entries, and the output buffer has room for the data still to
// arrive, a read is issued to the synchronous-read storage array. Returned
// words go into a two-entry buffer (head + skid) that drives a valid/ready
// stream. The read pointer goes back to the write domain in Gray code.
//
// Ports
//   clk            in   read-domain clock
//   rstn           in   asynchronous active-low reset
//   wptr_gray_sync in   write pointer (Gray), synchronized into clk
//   rptr_gray      out  registered read pointer (Gray) for the write domain
//   rd_en          out  storage read strobe
//   raddr          out  storage read address
//   mem_rdata      in   storage read data, valid the cycle after rd_en
//   out_valid      out  out_data holds a FIFO word
//   out_ready      in   consumer accepts the word
//   out_data       out  head word
//   empty          out  no unread entries left in storage
//   level          out  entries in storage not yet read
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int ADDR_W = 3,
    parameter int W      = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W:0]   wptr_gray_sync,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              rd_en,
    output logic [ADDR_W-1:0] raddr,
    input  logic [W-1:0]      mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    // Buffer occupancy; the encoding equals the number of buffered words.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    buf_state_t state_q, state_d;

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] rbin_q, rbin_d;
    logic [ADDR_W:0] rptr_gray_q;
    logic            inflight_q;
    logic [W-1:0]    head_q, head_d;
    logic [W-1:0]    skid_q, skid_d;

    logic [1:0]      cnt;
    logic            pop;
    logic            arrival;
    logic [2:0]      occ_after;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or
    // above it, so any jump of the synchronized pointer decodes correctly.
    genvar gi;
    generate
        for (gi = 0; gi <= ADDR_W; gi++) begin : g_gray_dec
            assign wbin[gi] = ^wptr_gray_sync[ADDR_W:gi];
        end
    endgenerate

    assign raddr = rbin_q[ADDR_W-1:0];
    assign empty = (rbin_q == wbin);
    assign level = wbin - rbin_q;

    assign pop     = out_valid && out_ready;
    assign arrival = inflight_q;

    // Words that will be held after this cycle (buffered + in flight - popped).
    // A new read is only allowed if that leaves room for its data, which is
    // what guarantees no arrival can ever land in BUF_TWO.
    assign occ_after = {1'b0, cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en     = rstn && !empty && (occ_after < 3'd2);

    assign rbin_d = rbin_q + {{ADDR_W{1'b0}}, rd_en};

    // ------------------------------------------------------------------
    // Buffer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Buffer FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: begin
                if (arrival) state_d = BUF_ONE;
            end
            BUF_ONE: begin
                if (arrival && !pop)      state_d = BUF_TWO;
                else if (pop && !arrival) state_d = BUF_EMPTY;
            end
            BUF_TWO: begin
                if (pop && !arrival) state_d = BUF_ONE;
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Buffer FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 1'b0;
        cnt       = 2'd0;
        case (state_q)
            BUF_ONE: begin
                out_valid = 1'b1;
                cnt       = 2'd1;
            end
            BUF_TWO: begin
                out_valid = 1'b1;
                cnt       = 2'd2;
            end
            default: begin
                out_valid = 1'b0;
                cnt       = 2'd0;
            end
        endcase
    end

    // Data movement: a pop shifts skid into head, and an arrival fills
    // whichever slot is free after that shift, keeping FIFO order.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        case (state_q)
            BUF_EMPTY: begin
                if (arrival) head_d = mem_rdata;
            end
            BUF_ONE: begin
                if (arrival) begin
                    if (pop) head_d = mem_rdata;
                    else     skid_d = mem_rdata;
                end
            end
            BUF_TWO: begin
                if (pop) begin
                    head_d = skid_q;
                    if (arrival) skid_d = mem_rdata;
                end
            end
            default: begin
                head_d = head_q;
                skid_d = skid_q;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pointer and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            inflight_q  <= 1'b0;
            head_q      <= '0;
            skid_q      <= '0;
        end else begin
            rbin_q      <= rbin_d;
            // Derived from the registered next pointer so the crossing
            // signal changes in at most one bit per clock.
            rptr_gray_q <= rbin_d ^ (rbin_d >> 1);
            inflight_q  <= rd_en;
            head_q      <= head_d;
            skid_q      <= skid_d;
        end
    end

    assign rptr_gray = rptr_gray_q;
    assign out_data  = head_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    localparam int ADDR_W = 3;
    localparam int W      = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn;
    logic [ADDR_W:0]   wptr_gray_sync;
    logic [ADDR_W:0]   rptr_gray;
    logic              rd_en;
    logic [ADDR_W-1:0] raddr;
    logic [W-1:0]      mem_rdata = '0;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic              empty;
    logic [ADDR_W:0]   level;

    fifo_rd_ctrl #(.ADDR_W(ADDR_W), .W(W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .wptr_gray_sync (wptr_gray_sync),
        .rptr_gray      (rptr_gray),
        .rd_en          (rd_en),
        .raddr          (raddr),
        .mem_rdata      (mem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .empty          (empty),
        .level          (level)
    );

    always #5 clk = ~clk;

    // Reference model: words written (writer side), reads observed, pops.
    int         vectors     = 0;
    int         miscompares = 0;
    int         wr_cnt      = 0;
    int         rd_count    = 0;
    int         pop_count   = 0;
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] exp_q [$];

    function automatic logic [ADDR_W:0] gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ADDR_W:0] wbin_tb;
    assign wbin_tb        = wr_cnt[ADDR_W:0];
    assign wptr_gray_sync = gray(wbin_tb);

    // Synchronous-read storage
    always @(posedge clk) begin
        if (rd_en) mem_rdata <= mem[raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic write_word();
        logic [W-1:0] d;
        d = W'($urandom);
        mem[wr_cnt[ADDR_W-1:0]] = d;
        exp_q.push_back(d);
        wr_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        wr_cnt    = 0;
        rd_count  = 0;
        pop_count = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rstn      = 1'b0;
        out_ready = 1'b0;
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Monitor / scoreboard: runs every cycle away from the active edge.
    initial begin
        int lvl;
        forever begin
            @(negedge clk);
            if (rstn) begin
                lvl = wr_cnt - rd_count;
                assert (lvl >= 0 && lvl <= DEPTH) else begin
                    miscompares++;
                    $display("FAIL illegal_level: got %0d expected <= %0d", lvl, DEPTH);
                end
                check("level", 32'(level), 32'(lvl));
                check("empty", 32'(empty), 32'(lvl == 0));
                check("rptr_gray", 32'(rptr_gray), 32'(gray(rd_count[ADDR_W:0])));
                if (rd_en) begin
                    check("raddr", 32'(raddr), 32'(rd_count % DEPTH));
                    check("rd_when_nonempty", 32'(lvl > 0), 32'd1);
                    rd_count++;
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("valid_without_word", 32'(out_valid), 32'd0);
                    end else begin
                        check("out_data", 32'(out_data), 32'(exp_q[0]));
                        if (out_ready) begin
                            $display("pop %0d data=%0h", pop_count, out_data);
                            void'(exp_q.pop_front());
                            pop_count++;
                        end
                    end
                end
                check("outstanding_le2", 32'(rd_count - pop_count <= 2), 32'd1);
            end
        end
    end

    initial begin
        int rd_seen;
        int n;
        rstn      = 1'b1;
        out_ready = 1'b0;
        clear_model();

        // Reset asserted with no clock edge: outputs clear immediately.
        #1 rstn = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_rd_en",     32'(rd_en),     32'd0);
        check("rst_rptr_gray", 32'(rptr_gray), 32'd0);
        check("rst_empty",     32'(empty),     32'd1);
        check("rst_level",     32'(level),     32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Single word, consumer stalled.
        tick();
        write_word();
        #1;
        check("single_rd_en", 32'(rd_en), 32'd1);
        check("single_raddr", 32'(raddr), 32'd0);
        tick();
        check("single_rptr_gray", 32'(rptr_gray), 32'd1);
        check("single_empty",     32'(empty),     32'd1);
        check("single_valid_c1",  32'(out_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("single_valid_hold", 32'(out_valid), 32'd1);
            check("single_data_hold",  32'(out_data),  32'(mem[0]));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_drained", 32'(out_valid), 32'd0);

        // Full stream, one word per cycle.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) write_word();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("stream_rd_en", 32'(rd_en),     32'(k < DEPTH));
            check("stream_valid", 32'(out_valid), 32'(k >= 2 && k < DEPTH + 2));
        end

        // Back-pressure: only two reads, then gapless restart.
        do_reset();
        for (int k = 0; k < DEPTH; k++) write_word();
        rd_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rd_seen += int'(rd_en);
        end
        check("bp_reads", 32'(rd_seen), 32'd2);
        check("bp_level", 32'(level), 32'd6);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_restart_valid", 32'(out_valid), 32'(k < DEPTH));
        end

        // Pointer wrap after 16 words.
        do_reset();
        out_ready = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < DEPTH; k++) write_word();
            repeat (12) tick();
        end
        check("wrap_rptr_gray", 32'(rptr_gray), 32'd0);
        check("wrap_empty",     32'(empty),     32'd1);
        check("wrap_level",     32'(level),     32'd0);
        write_word();
        #1;
        check("wrap_rd_en",  32'(rd_en), 32'd1);
        check("wrap_raddr",  32'(raddr), 32'd0);
        repeat (4) tick();

        // Reset mid-operation with data in the buffer and a read in flight.
        do_reset();
        for (int k = 0; k < DEPTH; k++) write_word();
        tick();
        tick();
        check("midrst_pre_valid", 32'(out_valid), 32'd1);
        check("midrst_pre_rptr",  32'(rptr_gray), 32'(gray(4'd2)));
        #2;
        rstn = 1'b0;
        clear_model();
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_rptr",  32'(rptr_gray), 32'd0);
        check("midrst_rd_en", 32'(rd_en),     32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random back-pressure.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            tick();
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                if (wr_cnt - rd_count < DEPTH) write_word();
            end
            out_ready = (c % 200 > 170) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) tick();
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        check("drain_all_popped", 32'(pop_count), 32'(wr_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
